// File: rtl/oven_pkg.sv
// Shared definitions for the oven cook controller: state encodings,
// the BCD digit type, the 99:59 ceiling and BCD/binary helpers.
package oven_pkg;

  typedef logic [3:0] bcd_t;

  // State encodings are visible on the state output, so keep them fixed
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Largest displayable time, 99:59
  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [5:0] MAX_SEC = 6'd59;

  // Two BCD digits -> binary 0..99
  function automatic logic [6:0] from_bcd(input bcd_t tens, input bcd_t ones);
    return {3'b000, tens} * 7'd10 + {3'b000, ones};
  endfunction

  // Binary 0..99 -> {tens, ones}
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] o;
    t = v / 7'd10;
    o = v - t * 7'd10;
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS time register held as four BCD digits. Supports clear, load of a
// seconds value, adding 10 s and/or 1 min with a 99:59 ceiling, and a
// 1 s decrement with borrow that may be applied on top of an add.
// Priority: clr > load > add/decrement.
module bcd_mmss_counter
  import oven_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic       add_min,
  input  logic       add_10s,
  input  logic       dec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       is_zero,
  output logic       is_one
);

  logic [6:0] m, m_a, m_n;
  logic [5:0] s, s_a, s_n;
  logic [6:0] s_sum;
  logic [7:0] m_sum;
  logic       carry;

  // Work in binary minutes/seconds; digits are re-encoded on the way in
  assign m = from_bcd(min_tens, min_ones);
  assign s = 6'(from_bcd(sec_tens, sec_ones));

  assign is_zero = (m == 7'd0) && (s == 6'd0);
  assign is_one  = (m == 7'd0) && (s == 6'd1);

  // Next time: saturating add first, then the optional 1 s borrow-decrement
  always_comb begin
    s_sum = {1'b0, s} + (add_10s ? 7'd10 : 7'd0);
    carry = (s_sum >= 7'd60);
    s_a   = carry ? 6'(s_sum - 7'd60) : s_sum[5:0];
    m_sum = {1'b0, m} + {7'd0, add_min} + {7'd0, carry};
    m_a   = m_sum[6:0];
    if (m_sum > {1'b0, MAX_MIN}) begin
      m_a = MAX_MIN;
      s_a = MAX_SEC;
    end
    m_n = m_a;
    s_n = s_a;
    if (dec) begin
      if (s_a != 6'd0) begin
        s_n = s_a - 6'd1;
      end else if (m_a != 7'd0) begin
        m_n = m_a - 7'd1;
        s_n = MAX_SEC;
      end
    end
    if (load) begin
      m_n = 7'd0;
      s_n = load_sec;
    end
    if (clr) begin
      m_n = 7'd0;
      s_n = 6'd0;
    end
  end

  // Store the time back as BCD digits so the outputs come straight from flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      {min_tens, min_ones} <= to_bcd(m_n);
      {sec_tens, sec_ones} <= to_bcd({1'b0, s_n});
    end
  end

endmodule

// File: rtl/oven_cook_controller.sv
// Microwave/oven cook controller: keypad time entry, countdown cooking,
// pause on door/stop, and a completion alarm.
// Optional feature macro OVEN_ALARM_TIMEOUT_EN: when defined, the DONE
// alarm clears itself after ALARM_SECS ticks; otherwise DONE persists
// until key_stop or the door is opened.
module oven_cook_controller
  import oven_pkg::*;
#(
  parameter int ALARM_SECS = 5,
  parameter int QUICK_SECS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_add_min,
  input  logic       key_add_10s,
  input  logic       key_start,
  input  logic       key_stop,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heater_on,
  output logic       lamp_on,
  output logic       alarm,
  output logic [2:0] state
);

  logic [2:0] state_nxt;
  logic       c_clr, c_load, c_add_min, c_add_10s, c_dec;
  logic       is_zero, is_one;
  logic       door_prev, door_rise;
  logic       any_add, start_ok;
  logic       alarm_expire;

  assign any_add   = key_add_min | key_add_10s;
  assign start_ok  = key_start & ~door_open;
  assign door_rise = door_open & ~door_prev;

  bcd_mmss_counter u_time (
    .clk      (clk),
    .reset    (reset),
    .clr      (c_clr),
    .load     (c_load),
    .load_sec (6'(QUICK_SECS)),
    .add_min  (c_add_min),
    .add_10s  (c_add_10s),
    .dec      (c_dec),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .is_zero  (is_zero),
    .is_one   (is_one)
  );

`ifdef OVEN_ALARM_TIMEOUT_EN
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  logic [AW-1:0] alarm_cnt;

  // Count ticks spent in DONE; cleared whenever we are elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  alarm_cnt <= '0;
    else if (state != ST_DONE)  alarm_cnt <= '0;
    else if (tick)              alarm_cnt <= alarm_cnt + 1'b1;
  end

  assign alarm_expire = (state == ST_DONE) && tick && (alarm_cnt == AW'(ALARM_SECS - 1));
`else
  assign alarm_expire = 1'b0;
`endif

  // Next-state and time-counter control; key_stop > door_open > key_start > adds
  always_comb begin
    state_nxt = state;
    c_clr     = 1'b0;
    c_load    = 1'b0;
    c_add_min = 1'b0;
    c_add_10s = 1'b0;
    c_dec     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_stop) begin
          c_clr = 1'b1;
        end else if (start_ok) begin
          c_load    = 1'b1;
          state_nxt = ST_COOK;
        end else if (any_add) begin
          c_add_min = key_add_min;
          c_add_10s = key_add_10s;
          state_nxt = ST_SET;
        end
      end
      ST_SET: begin
        if (key_stop) begin
          c_clr     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (start_ok) begin
          state_nxt = ST_COOK;
        end else begin
          c_add_min = key_add_min;
          c_add_10s = key_add_10s;
        end
      end
      ST_COOK: begin
        // Door or stop freezes the time, swallowing any tick this cycle
        if (key_stop || door_open) begin
          state_nxt = ST_PAUSE;
        end else begin
          c_add_min = key_add_min;
          c_add_10s = key_add_10s;
          c_dec     = tick;
          // Only an add-free tick can bring the time to zero
          if (tick && !any_add && (is_zero || is_one)) state_nxt = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (key_stop) begin
          c_clr     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (start_ok) begin
          state_nxt = ST_COOK;
        end
      end
      ST_DONE: begin
        if (key_stop || door_rise || alarm_expire) begin
          c_clr     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        c_clr     = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, door history and registered indicator outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      door_prev <= 1'b0;
      heater_on <= 1'b0;
      lamp_on   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_nxt;
      door_prev <= door_open;
      heater_on <= (state_nxt == ST_COOK);
      lamp_on   <= door_open | (state_nxt == ST_COOK);
      alarm     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_oven_cook_controller.sv
// Directed bench for oven_cook_controller. A model tracks remaining time
// as a plain seconds count and is compared with the DUT every cycle;
// literal checks pin the model at key points.
module tb_oven_cook_controller;

  localparam int QUICK = 30;
  localparam int ALARM = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, key_add_min = 1'b0, key_add_10s = 1'b0;
  logic key_start = 1'b0, key_stop = 1'b0, door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic heater_on, lamp_on, alarm;
  logic [2:0] state;

  int checks = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  // Model state
  int m_st, m_t, m_acnt;
  bit m_heat, m_lamp, m_alarm, m_dprev;

  oven_cook_controller #(.ALARM_SECS(ALARM), .QUICK_SECS(QUICK)) dut (
    .clk(clk), .reset(rst), .tick(tick),
    .key_add_min(key_add_min), .key_add_10s(key_add_10s),
    .key_start(key_start), .key_stop(key_stop), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heater_on(heater_on), .lamp_on(lamp_on), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > 5999) ? 5999 : x;
  endfunction

  function automatic logic [21:0] exp_vec();
    int mm, ss;
    mm = m_t / 60;
    ss = m_t % 60;
    return {3'(m_st), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_heat, m_lamp, m_alarm};
  endfunction

  logic [21:0] dut_vec;
  assign dut_vec = {state, min_tens, min_ones, sec_tens, sec_ones, heater_on, lamp_on, alarm};

  task automatic model_reset();
    m_st = 0; m_t = 0; m_acnt = 0;
    m_heat = 0; m_lamp = 0; m_alarm = 0; m_dprev = 0;
  endtask

  // One clock of the oven rules, in seconds
  task automatic model_step();
    int add;
    bit sok, rise;
    add  = (key_add_min ? 60 : 0) + (key_add_10s ? 10 : 0);
    sok  = key_start && !door_open;
    rise = door_open && !m_dprev;
    case (m_st)
      0: if (key_stop) m_t = 0;
         else if (sok) begin m_t = QUICK; m_st = 2; end
         else if (add > 0) begin m_t = sat(m_t + add); m_st = 1; end
      1: if (key_stop) begin m_t = 0; m_st = 0; end
         else if (sok) m_st = 2;
         else m_t = sat(m_t + add);
      2: if (key_stop || door_open) m_st = 3;
         else begin
           m_t = sat(m_t + add);
           if (tick) begin
             if (m_t > 0) m_t = m_t - 1;
             if (m_t == 0) m_st = 4;
           end
         end
      3: if (key_stop) begin m_t = 0; m_st = 0; end
         else if (sok) m_st = 2;
      4: begin
           if (key_stop || rise) begin m_st = 0; m_t = 0; end
`ifdef OVEN_ALARM_TIMEOUT_EN
           else if (tick) begin
             m_acnt = m_acnt + 1;
             if (m_acnt == ALARM) begin m_st = 0; m_t = 0; end
           end
`endif
         end
      default: m_st = 0;
    endcase
    if (m_st != 4) m_acnt = 0;
    m_dprev = door_open;
    m_heat  = (m_st == 2);
    m_lamp  = door_open || m_heat;
    m_alarm = (m_st == 4);
  endtask

  // One clock with the given key pulses; door_open is a held level
  task automatic cyc(input logic stp, input logic sta, input logic am, input logic a10, input logic tk);
    key_stop = stp; key_start = sta; key_add_min = am; key_add_10s = a10; tick = tk;
    @(posedge clk);
    model_step();
    #1;
    key_stop = 0; key_start = 0; key_add_min = 0; key_add_10s = 0; tick = 0;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errs++;
        $display("FAIL per_cycle t=%0t got=%h want=%h", $time, dut_vec, exp_vec());
      end
    end
  end

  function automatic logic [15:0] tm();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    lit("reset_state", {state, heater_on, lamp_on, alarm}, 32'h0);
    lit("reset_time", tm(), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Set 02:10 and cook it down to zero
    cyc(0,0,1,0,0); cyc(0,0,1,0,0); cyc(0,0,0,1,0);
    lit("set_0210", tm(), 16'h0210);
    lit("set_state", state, 3'd1);
    cyc(0,1,0,0,0);
    lit("cook_heater", {state, heater_on}, {3'd2, 1'b1});
    for (int i = 1; i <= 130; i++) begin
      cyc(0,0,0,0,1);
      cyc(0,0,0,0,0);
      if (i == 70)  lit("cook_0100", tm(), 16'h0100);
      if (i == 129) lit("cook_0001", {state, tm()}, {3'd2, 16'h0001});
    end
    lit("done_flags", {state, heater_on, alarm}, {3'd4, 1'b0, 1'b1});
    lit("done_time", tm(), 16'h0000);

    // Alarm after 5 further ticks
    repeat (5) begin cyc(0,0,0,0,1); cyc(0,0,0,0,0); end
`ifdef OVEN_ALARM_TIMEOUT_EN
    lit("alarm_timeout", {state, alarm}, {3'd0, 1'b0});
`else
    lit("alarm_persist", {state, alarm}, {3'd4, 1'b1});
`endif
    cyc(1,0,0,0,0);
    lit("stop_to_idle", state, 3'd0);

    // Door open during a tick pauses at 01:00
    cyc(0,0,1,0,0); cyc(0,1,0,0,0);
    door_open = 1'b1;
    cyc(0,0,0,0,1);
    lit("pause_flags", {state, heater_on, lamp_on}, {3'd3, 1'b0, 1'b1});
    lit("pause_time", tm(), 16'h0100);
    cyc(0,0,0,0,1);
    cyc(0,1,0,0,0);
    lit("pause_start_door", {state, tm()}, {3'd3, 16'h0100});
    door_open = 1'b0;
    cyc(0,1,0,0,0);
    lit("resume", {state, heater_on, lamp_on}, {3'd2, 1'b1, 1'b1});

    // Tick plus add in the same cycle
    cyc(0,0,0,0,1);
    lit("cook_0059", tm(), 16'h0059);
    cyc(0,0,1,0,1);
    lit("tick_add_min", tm(), 16'h0158);
    cyc(0,0,1,1,1);
    lit("tick_add_both", tm(), 16'h0307);
    cyc(1,0,0,0,0); cyc(1,0,0,0,0);
    lit("pause_stop_clear", {state, tm()}, {3'd0, 16'h0000});

    // Seconds carry into minutes
    repeat (6) cyc(0,0,0,1,0);
    lit("carry_0100", tm(), 16'h0100);
    cyc(1,0,0,0,0);

    // Saturation at 99:59
    repeat (99) cyc(0,0,1,0,0);
    repeat (5) cyc(0,0,0,1,0);
    lit("set_9950", tm(), 16'h9950);
    cyc(0,0,1,0,0);
    lit("sat_min", tm(), 16'h9959);
    cyc(0,0,0,1,0);
    lit("sat_10s", tm(), 16'h9959);
    cyc(0,0,1,1,0);
    cyc(1,0,0,0,0);

    // Quick start and stop/start priority
    cyc(0,1,0,0,0);
    lit("quick_start", {state, tm()}, {3'd2, 16'h0030});
    cyc(1,0,0,0,0); cyc(1,0,0,0,0);
    cyc(1,1,0,0,0);
    lit("stop_beats_start", {state, tm()}, {3'd0, 16'h0000});
    door_open = 1'b1;
    cyc(0,1,0,0,0);
    lit("start_door_open", {state, lamp_on}, {3'd0, 1'b1});
    door_open = 1'b0;
    cyc(0,0,0,0,0);

    // Door rising edge leaves DONE
    cyc(0,1,0,0,0);
    repeat (30) cyc(0,0,0,0,1);
    lit("quick_done", state, 3'd4);
    door_open = 1'b1;
    cyc(0,0,0,0,0);
    lit("door_exit_done", {state, alarm, lamp_on}, {3'd0, 1'b0, 1'b1});
    door_open = 1'b0;
    cyc(0,0,0,0,0);

    // Asynchronous reset mid-cook
    cyc(0,1,0,0,0); cyc(0,0,0,0,1); cyc(0,0,0,0,1);
    lit("pre_reset", tm(), 16'h0028);
    #2 rst = 1'b1;
    model_reset();
    #1;
    lit("async_reset", {state, heater_on, lamp_on, alarm, tm()}, {3'd0, 3'd0, 16'h0000});
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0,0,1,0,0);
    lit("post_reset_add", {state, tm()}, {3'd1, 16'h0100});
    cyc(1,0,0,0,0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/oven_cook_controller.md
OVEN_COOK_CONTROLLER -- requirements
Module: oven_cook_controller

Interface
REQ-001 Parameter ALARM_SECS, default 5: tick count before the DONE alarm auto-clears (used only with OVEN_ALARM_TIMEOUT_EN).
REQ-002 Parameter QUICK_SECS, default 30: seconds loaded by quick-start from IDLE (0..59).
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 tick  input  1  one-clk pulse once per second, synchronous to clk.
REQ-006 key_add_min  input  1  one-clk pulse; add 1 minute.
REQ-007 key_add_10s  input  1  one-clk pulse; add 10 seconds.
REQ-008 key_start  input  1  one-clk pulse; start or resume.
REQ-009 key_stop  input  1  one-clk pulse; pause or cancel.
REQ-010 door_open  input  1  level; 1 = door open.
REQ-011 min_tens, min_ones, sec_tens, sec_ones  output  4 each  remaining time, BCD MM:SS.
REQ-012 heater_on  output  1  magnetron/heater enable.
REQ-013 lamp_on  output  1  cavity lamp.
REQ-014 alarm  output  1  cook-complete alarm.
REQ-015 state  output  3  current FSM state encoding.

Function
REQ-016 All outputs are registered; each responds on the first posedge after the sampling edge (1-cycle latency).
REQ-017 States: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4; no other encodings reachable.
REQ-018 IDLE: time 00:00; add key loads the time and moves to SET; key_start with door closed loads 00:QUICK_SECS and moves to COOK.
REQ-019 SET: add keys accumulate with BCD carry (sec 59 -> min +1); total saturates at 99:59; key_start with door closed -> COOK; key_stop -> IDLE, time cleared.
REQ-020 COOK: each tick decrements the time by 1 s with BCD borrow (MM:00 -> (MM-1):59); tick at 00:01 -> 00:00 and DONE; add keys remain active.
REQ-021 COOK: door_open or key_stop -> PAUSE, time frozen; a tick in that same cycle is ignored.
REQ-022 PAUSE: key_start with door closed -> COOK; key_stop -> IDLE, time cleared; ticks ignored.
REQ-023 DONE: alarm=1, time 00:00; key_stop or a door_open rising edge -> IDLE.
REQ-024 Priority, same cycle: key_stop > door_open > key_start > add keys.
REQ-025 In COOK, tick together with an add key applies both: new time = saturate(time + add) - 1 s.
REQ-026 key_add_min and key_add_10s together add 70 s.
REQ-027 key_start with door_open=1 is ignored in every state.
REQ-028 heater_on=1 only in COOK; lamp_on = door_open OR heater_on; alarm=1 only in DONE.

Reset
REQ-029 reset asserted: state=IDLE, time 00:00, heater_on=0, lamp_on=0, alarm=0, alarm counter 0, regardless of state or in-flight ticks.
REQ-030 After reset deassertion, the first clock edge already samples inputs normally; no pulse captured before deassertion is retained.

Configuration
REQ-031 Macro OVEN_ALARM_TIMEOUT_EN defined: DONE counts ticks; after ALARM_SECS ticks the FSM goes to IDLE and alarm clears.
REQ-032 Macro OVEN_ALARM_TIMEOUT_EN undefined: no alarm counter exists; DONE persists until key_stop or door_open.

Structure
REQ-033 Shared package oven_pkg holds the state enum, the 4-bit BCD digit typedef and the 99:59 saturation constants.
REQ-034 One sub-module, bcd_mmss_counter: load/clear, add seconds with saturation and decrement with borrow; the FSM instantiates it once.

Verification
REQ-035 Reset, key_add_min x2, key_add_10s, key_start, 130 ticks -> time counts 02:10 down to 00:00, DONE, heater_on 1->0, alarm=1.
REQ-036 COOK at 01:00; door_open=1 on a tick cycle -> PAUSE, time stays 01:00, heater_on=0, lamp_on=1; door closed + key_start -> COOK.
REQ-037 SET at 99:50, key_add_min -> 99:59 saturated; a further key_add_10s -> 99:59 unchanged.
REQ-038 COOK at 00:59, tick + key_add_min same cycle -> 01:58.
REQ-039 IDLE, key_start with door closed -> COOK at 00:30; same-cycle key_stop + key_start -> stays IDLE.
REQ-040 With OVEN_ALARM_TIMEOUT_EN: DONE plus 5 ticks -> IDLE, alarm=0; without it: DONE plus 5 ticks -> still DONE, alarm=1; reset asserted mid-COOK -> IDLE, 00:00 immediately.
